imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory.
- Accepts a byte stream (UART receiver or debug port) over a valid/ready handshake.
- Assembles 32-bit instruction words and issues word-aligned writes to the instruction memory write port.
- Holds the CPU in reset while a program is being loaded, so the core never fetches a partially written image.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in instruction memory; maximum load length.
- ADDR_W, 8, byte-address width of the write address; matches the fetch PC width.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle pulse; begins a load session when idle.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready).
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  ADDR_W  byte address of the word being written; always a multiple of 4.
- wr_data  output  32  instruction word.
- busy  output  1  session in progress.
- cpu_hold  output  1  CPU reset/hold request; equals busy.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky checksum error (optional feature); cleared by the next load_start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, wr_en, busy, cpu_hold, done, err = 0; wr_addr = 0; wr_data = 0; byte counter, word counter and checksum accumulator = 0.
- Reset mid-session aborts immediately, with no further writes. Memory contents already written are left as-is.
- IDLE: in_ready=0. On load_start=1, go to COUNT: busy=1, wr_addr=0, word counter=0, err cleared.
- COUNT: in_ready=1. The first accepted byte N is the word count.
  - N=0 means DEPTH_WORDS.
  - N>DEPTH_WORDS is clamped to DEPTH_WORDS.
  - Then go to BYTES.
- BYTES: in_ready=1. Bytes are accepted big-endian: the first byte goes to wr_data[31:24], the last to [7:0]. This matches hex-file word order.
  - When the 4th byte is accepted, go to WRITE.
- WRITE: in_ready=0. wr_en=1 for exactly one cycle with the current wr_addr and wr_data.
  - Next cycle: wr_addr += 4 and word counter += 1.
  - If the word counter reaches N, go to CKSUM (feature enabled) or FIN. Otherwise return to BYTES.
- Latency: wr_en is asserted on the cycle after the 4th byte's transfer edge.
- FIN: done=1 for one cycle, busy and cpu_hold drop in the same cycle, next state IDLE.
- Handshake rules:
  - in_valid with in_ready=0 is not consumed; the source must hold the byte.
  - in_valid gaps of any length are allowed and inserted wait cycles never corrupt assembly.
  - At most one byte is accepted per cycle.
- load_start while busy is ignored.
- wr_addr never exceeds (DEPTH_WORDS-1)*4 because N is clamped; there is no wrap within a session.
- wr_data holds its last value outside WRITE.
- Outputs are registered, except in_ready, which is decoded from state.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Enabled:
  - An 8-bit accumulator sums all data bytes mod 256; the count byte is excluded.
  - After the last WRITE, state CKSUM accepts one more byte (in_ready=1).
  - If that byte is not equal to the accumulator, err=1 (sticky).
  - Then FIN. done still pulses, and the image remains written.
- Disabled: no CKSUM state, no trailing byte, and err is tied to 0.

Test Plan:
- Reset then single word: load_start, bytes 01,00,00,00,13 (+ checksum 13 if enabled) -> one wr_en, wr_addr=0x00, wr_data=0x00000013; done pulse; busy and cpu_hold 1 during the session, 0 after.
- Three words with random in_valid gaps, bytes 03 then DEADBEEF 12345678 00A00093 -> writes at addresses 0x00, 0x04, 0x08 with those exact words; in_ready=0 during each WRITE cycle.
- Count 0 and count 200 -> exactly 64 writes each, last wr_addr=0xFC, then done.
- Checksum (enabled): data 01 02 03 04 with trailing byte 0x0A -> err=0; same with trailing byte 0x0B -> err=1 and still done; the next load_start clears err.
- rst_n pulled low after 2 of 4 bytes of word 1 -> all outputs 0 asynchronously; a new session after release writes a clean word at address 0x00.
- load_start pulsed mid-session -> ignored: wr_addr sequence and write count unchanged.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: count byte + big-endian words -> word writes, CPU held meanwhile.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_start_i,
    imem_loader_if.slave bus,
    output logic         busy_o,
    output logic         cpu_hold_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int CNT_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTES,
        S_WRITE,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_FIN
    } state_t;

    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  nwords_q;
    logic [23:0]       asm_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              busy_q;
    logic              done_q;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        sum_q;
    logic              err_q;
`endif

    logic              in_ready;
    logic              xfer;
    logic [CNT_W-1:0]  nwords_d;
    logic [CNT_W-1:0]  word_cnt_d;
    logic              last_word;

    always_comb begin
        in_ready = (state_q == S_COUNT) || (state_q == S_BYTES);
`ifdef IMEM_LOADER_CKSUM_EN
        in_ready = in_ready || (state_q == S_CKSUM);
`endif
        xfer = bus.in_valid & in_ready;
        // Zero or oversized count loads the whole memory.
        if (bus.in_data == 8'd0 || 32'(bus.in_data) > 32'(DEPTH_WORDS))
            nwords_d = CNT_W'(DEPTH_WORDS);
        else
            nwords_d = CNT_W'(bus.in_data);
        word_cnt_d = word_cnt_q + 1'b1;
        last_word  = (word_cnt_d == nwords_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            nwords_q   <= '0;
            asm_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start_i) begin
                        state_q    <= S_COUNT;
                        busy_q     <= 1'b1;
                        wr_addr_q  <= '0;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_q      <= '0;
                        err_q      <= 1'b0;
`endif
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        nwords_q <= nwords_d;
                        state_q  <= S_BYTES;
                    end
                end
                S_BYTES: begin
                    if (xfer) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        asm_q      <= {asm_q[15:0], bus.in_data};
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_q      <= sum_q + bus.in_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            wr_data_q <= {asm_q, bus.in_data};
                            wr_en_q   <= 1'b1;
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt_q <= word_cnt_d;
                    if (last_word) begin
                        // Address stays on the final word so it never wraps.
`ifdef IMEM_LOADER_CKSUM_EN
                        state_q <= S_CKSUM;
`else
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(4);
                        state_q   <= S_BYTES;
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        if (bus.in_data != sum_q)
                            err_q <= 1'b1;
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy_o       = busy_q;
    assign cpu_hold_o   = busy_q;
    assign done_o       = done_q;
`ifdef IMEM_LOADER_CKSUM_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, gapped words, count clamp, checksum,
// mid-session reset and ignored load_start.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic load_start = 1'b0;
    logic busy, cpu_hold, done, err;

    int checks = 0;
    int errors = 0;
    int rdy_viol = 0;
    int hold_viol = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  csum;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.DEPTH_WORDS(64), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start),
        .bus          (bus),
        .busy_o       (busy),
        .cpu_hold_o   (cpu_hold),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            if (bus.in_ready) rdy_viol++;
        end
        if (busy != cpu_hold) hold_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] tmp;
        logic [7:0]  b;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            b = tmp[31:24];
            tmp = tmp << 8;
            csum = csum + b;
            send_byte(b, $urandom_range(0, maxgap));
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic start_session();
        wa.delete();
        wd.delete();
        csum = 8'h00;
        pulse_start();
    endtask

    task automatic end_cksum();
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(csum, 0);
`endif
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    logic [31:0] exp3[3];
    logic [31:0] w;
    logic [7:0]  ib;

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #4;
        check("rst_busy", 32'(busy), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", bus.wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word
        start_session();
        check("t1_busy", 32'(busy), 1);
        check("t1_cpu_hold", 32'(cpu_hold), 1);
        check("t1_ready_count", 32'(bus.in_ready), 1);
        send_byte(8'h01, 0);
        send_word(32'h0000_0013, 0);
        check("t1_lat_wr_en", 32'(bus.wr_en), 1);
        check("t1_ready_in_write", 32'(bus.in_ready), 0);
        check("t1_lat_addr", 32'(bus.wr_addr), 32'h00);
        check("t1_lat_data", bus.wr_data, 32'h0000_0013);
        end_cksum();
        wait_done("t1");
        check("t1_nwr", 32'(wa.size()), 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_hold_after", 32'(cpu_hold), 0);

        // Three words, random gaps
        exp3[0] = 32'hDEAD_BEEF;
        exp3[1] = 32'h1234_5678;
        exp3[2] = 32'h00A0_0093;
        start_session();
        send_byte(8'h03, 2);
        for (int i = 0; i < 3; i++) send_word(exp3[i], 3);
        end_cksum();
        wait_done("t2");
        check("t2_nwr", 32'(wa.size()), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            check($sformatf("t2_addr%0d", i), 32'(wa[i]), 32'(i * 4));
            check($sformatf("t2_data%0d", i), wd[i], exp3[i]);
        end
        check("t2_ready_in_write", 32'(rdy_viol), 0);

        // Count 0 and 200 both load 64 words
        for (int k = 0; k < 2; k++) begin
            start_session();
            send_byte((k == 0) ? 8'd0 : 8'd200, 0);
            for (int i = 0; i < 64; i++) begin
                ib = 8'(i);
                send_word({ib, 8'h5A, ~ib, 8'(k)}, 0);
            end
            end_cksum();
            wait_done($sformatf("t3_%0d", k));
            check($sformatf("t3_%0d_nwr", k), 32'(wa.size()), 64);
            if (wa.size() == 64) begin
                check($sformatf("t3_%0d_first_addr", k), 32'(wa[0]), 32'h00);
                check($sformatf("t3_%0d_last_addr", k), 32'(wa[63]), 32'hFC);
                check($sformatf("t3_%0d_last_data", k), wd[63], {8'd63, 8'h5A, 8'hC0, 8'(k)});
            end
            check($sformatf("t3_%0d_idle_ready", k), 32'(bus.in_ready), 0);
        end

`ifdef IMEM_LOADER_CKSUM_EN
        start_session();
        send_byte(8'h01, 0);
        send_word(32'h0102_0304, 1);
        send_byte(8'h0A, 0);
        wait_done("t4a");
        check("t4a_err", 32'(err), 0);
        start_session();
        send_byte(8'h01, 0);
        send_word(32'h0102_0304, 1);
        send_byte(8'h0B, 0);
        wait_done("t4b");
        check("t4b_err", 32'(err), 1);
        check("t4b_nwr", 32'(wa.size()), 1);
        start_session();
        check("t4c_err_cleared", 32'(err), 0);
        send_byte(8'h01, 0);
        send_word(32'h0102_0304, 0);
        send_byte(8'h0A, 0);
        wait_done("t4c");
        check("t4c_err", 32'(err), 0);
`endif

        // Reset mid-word
        start_session();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_cpu_hold", 32'(cpu_hold), 0);
        check("t5_in_ready", 32'(bus.in_ready), 0);
        check("t5_wr_en", 32'(bus.wr_en), 0);
        check("t5_wr_addr", 32'(bus.wr_addr), 0);
        check("t5_wr_data", bus.wr_data, 0);
        check("t5_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        check("t5_no_write", 32'(wa.size()), 0);
        rst_n = 1'b1;
        @(negedge clk);
        start_session();
        send_byte(8'h01, 0);
        send_word(32'h1122_3344, 1);
        end_cksum();
        wait_done("t5b");
        check("t5b_nwr", 32'(wa.size()), 1);
        if (wa.size() == 1) begin
            check("t5b_addr", 32'(wa[0]), 32'h00);
            check("t5b_data", wd[0], 32'h1122_3344);
        end

        // load_start while busy is ignored
        start_session();
        pulse_start();
        send_byte(8'h03, 0);
        send_word(32'hCAFE_0001, 0);
        pulse_start();
        send_word(32'hCAFE_0002, 1);
        pulse_start();
        send_word(32'hCAFE_0003, 0);
        end_cksum();
        wait_done("t6");
        check("t6_nwr", 32'(wa.size()), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            check($sformatf("t6_addr%0d", i), 32'(wa[i]), 32'(i * 4));
            check($sformatf("t6_data%0d", i), wd[i], 32'hCAFE_0001 + 32'(i));
        end
        check("hold_eq_busy", 32'(hold_viol), 0);
        check("ready_in_write_all", 32'(rdy_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
